gray_mem_arbiter: RTL

//   Two-requester arbiter for the single-port gray-image memory (128x128 x 8b, 1-cycle sync read).

---
 rtl/gray_mem_pkg.sv | 32 +++
 rtl/gray_rr_pick.sv | 22 ++
 rtl/gray_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/gray_mem_pkg.sv
// Shared types and defaults for the gray-image memory arbiter.
// Holds the memory geometry, the arbiter state encoding and the port-id type
// used by gray_mem_arbiter and gray_rr_pick.
package gray_mem_pkg;

  localparam int AW_DEF        = 14;  // 128x128 pixels
  localparam int DW_DEF        = 8;   // one gray byte per pixel
  localparam int IMG_W         = 128;
  localparam int MAX_BURST_DEF = 9;   // one 3x3 window

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_0 = 2'd1,
    OWN_1 = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_0 = 1'b0;
  localparam port_id_t PORT_1 = 1'b1;

  // The port that is not p
  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

  // Ownership state reserved for port p
  function automatic arb_state_t own_state(input port_id_t p);
    return (p == PORT_1) ? OWN_1 : OWN_0;
  endfunction

endpackage

// File: rtl/gray_rr_pick.sv
// Two-way round-robin select: turns a request pair and a favoured-port
// pointer into a one-hot grant. Purely combinational.
module gray_rr_pick
  import gray_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   rr_ptr_i,
  output logic [1:0] gnt_o
);

  // A lone request always wins; a tie goes to the port the pointer favours
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (rr_ptr_i == PORT_1) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/gray_mem_arbiter.sv
// Two-requester arbiter for the single-port gray-image memory.
// Port 0 is the LBP window fetcher, port 1 the host/DMA loader or debug reader.
// Round-robin per access; read data is steered back to the issuing port one
// cycle after its grant.
// Build option: define GRAY_ARB_LOCK_EN to honour the lock inputs and build the
// OWN_0/OWN_1 burst states with a MAX_BURST forced hand-over. Without it the
// lock inputs are ignored and every cycle is an open round-robin.
module gray_mem_arbiter
  import gray_mem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          m0_req_i,
  input  logic          m0_lock_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_lock_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  logic [1:0] req_s;
  logic [1:0] elig_s;
  logic [1:0] gnt_s;
  logic       acc_s;
  port_id_t   win_s;

  port_id_t   rr_ptr_q, rr_ptr_d;
  logic       rd_pend_q, rd_pend_d;
  port_id_t   rd_tag_q, rd_tag_d;

  assign req_s = {m1_req_i, m0_req_i};

`ifdef GRAY_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          win_lock_s;
  port_id_t      owner_s;
  logic          owner_req_s;
  logic          owner_lock_s;

  // While a burst is locked only the owner may compete; nobody competes in reset
  always_comb begin
    elig_s = 2'b00;
    if (reset_i) begin
      elig_s = 2'b00;
    end else begin
      case (state_q)
        IDLE:    elig_s = req_s;
        OWN_0:   elig_s = {1'b0, req_s[0]};
        OWN_1:   elig_s = {req_s[1], 1'b0};
        default: elig_s = 2'b00;
      endcase
    end
  end

  // Lock request of the winner and request/lock of the current owner
  always_comb begin
    win_lock_s   = (win_s == PORT_1) ? m1_lock_i : m0_lock_i;
    owner_s      = (state_q == OWN_1) ? PORT_1 : PORT_0;
    owner_req_s  = (owner_s == PORT_1) ? m1_req_i : m0_req_i;
    owner_lock_s = (owner_s == PORT_1) ? m1_lock_i : m0_lock_i;
  end

  // Burst ownership: enter on a locked grant, leave on unlock, idle-release or MAX_BURST
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (acc_s && win_lock_s && (MAX_BURST > 1)) begin
          state_d     = own_state(win_s);
          burst_cnt_d = CNT_ONE;
        end else begin
          state_d     = IDLE;
          burst_cnt_d = CNT_ZERO;
        end
      end
      OWN_0, OWN_1: begin
        if (acc_s) begin
          // The grant that makes the count reach MAX_BURST is the last of the burst
          if (((burst_cnt_q + CNT_ONE) == CNT_MAX) || !win_lock_s) begin
            state_d     = IDLE;
            burst_cnt_d = CNT_ZERO;
          end else begin
            state_d     = state_q;
            burst_cnt_d = burst_cnt_q + CNT_ONE;
          end
        end else if (!owner_req_s && !owner_lock_s) begin
          state_d     = IDLE;
          burst_cnt_d = CNT_ZERO;
        end else begin
          state_d     = state_q;
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Burst state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      burst_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign busy_o = (state_q != IDLE) || rd_pend_q;
`else
  logic unused_lock_s;
  assign unused_lock_s = m0_lock_i ^ m1_lock_i;

  // Without locking every requester competes every cycle; nobody competes in reset
  always_comb begin
    elig_s = 2'b00;
    if (reset_i) begin
      elig_s = 2'b00;
    end else begin
      elig_s = req_s;
    end
  end

  assign busy_o = rd_pend_q;
`endif

  gray_rr_pick u_pick (
    .req_i    (elig_s),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt_s)
  );

  assign acc_s    = |gnt_s;
  assign m0_gnt_o = gnt_s[0];
  assign m1_gnt_o = gnt_s[1];

  // Put the winner's access on the memory bus; an idle bus drives zeros
  always_comb begin
    win_s       = PORT_0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {AW{1'b0}};
    mem_wdata_o = {DW{1'b0}};
    case (gnt_s)
      2'b01: begin
        win_s       = PORT_0;
        mem_en_o    = 1'b1;
        mem_we_o    = m0_we_i;
        mem_addr_o  = m0_addr_i;
        mem_wdata_o = m0_wdata_i;
      end
      2'b10: begin
        win_s       = PORT_1;
        mem_en_o    = 1'b1;
        mem_we_o    = m1_we_i;
        mem_addr_o  = m1_addr_i;
        mem_wdata_o = m1_wdata_i;
      end
      default: begin
        win_s       = PORT_0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {AW{1'b0}};
        mem_wdata_o = {DW{1'b0}};
      end
    endcase
  end

  // Every grant hands priority to the other port; a granted read is tagged for return
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rd_pend_d = 1'b0;
    rd_tag_d  = rd_tag_q;
    if (acc_s) begin
      rr_ptr_d  = other_port(win_s);
      rd_pend_d = ~mem_we_o;
      rd_tag_d  = win_s;
    end else begin
      rr_ptr_d  = rr_ptr_q;
      rd_pend_d = 1'b0;
      rd_tag_d  = rd_tag_q;
    end
  end

  // Pointer and read-return registers; reset drops any read in flight
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q  <= PORT_0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= PORT_0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  assign m0_rvalid_o = rd_pend_q && (rd_tag_q == PORT_0);
  assign m1_rvalid_o = rd_pend_q && (rd_tag_q == PORT_1);
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : {DW{1'b0}};
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : {DW{1'b0}};

endmodule
